// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared widths and FSM state encoding for the hazard controller
package hazard_pkg;

  localparam int REG_AW = 3;
  localparam int CNT_W  = 16;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    RUN    = 2'b00,
    FLUSH  = 2'b01,
    HALTED = 2'b10
  } state_e;

endpackage

// File: rtl/hz_cmp.sv
// rtl/hz_cmp.sv - one pipeline-stage destination vs. IF/ID source-register comparator
module hz_cmp
  import hazard_pkg::*;
(
  input  logic              reg_write,
  input  logic [REG_AW-1:0] wr_addr,
  input  logic [REG_AW-1:0] rs_addr,
  input  logic [REG_AW-1:0] rt_addr,
  input  logic              use_rs,
  input  logic              use_rt,
  output logic              hz
);

  assign hz = reg_write & ((use_rs & (wr_addr == rs_addr)) | (use_rt & (wr_addr == rt_addr)));

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - pipeline stall/flush/halt controller with saturating stall counter
// HAZARD_FORWARD_EN: when defined, only load-use hazards stall (forwarding covers the rest).
module hazard_ctrl
  import hazard_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] rsAddr,
  input  logic [REG_AW-1:0] rtAddr,
  input  logic              useRs,
  input  logic              useRt,
  input  logic [REG_AW-1:0] WrR_IDEX,
  input  logic [REG_AW-1:0] WrR_EXMEM,
  input  logic [REG_AW-1:0] WrR_MEMWB,
  input  logic              RegWrite_IDEX,
  input  logic              RegWrite_EXMEM,
  input  logic              RegWrite_MEMWB,
  input  logic              MemRead_IDEX,
  input  logic              takeBranch_EXMEM,
  input  logic              halt_MEMWB,
  input  logic              memBusy,
  output logic              pcEn,
  output logic              ifidEn,
  output logic              freeze,
  output logic              stallCtrl,
  output logic              flush,
  output logic [CNT_W-1:0]  stallCnt
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             hz_idex, hz_exmem, hz_memwb;
  logic             raw;

  hz_cmp u_cmp_idex (
    .reg_write(RegWrite_IDEX), .wr_addr(WrR_IDEX), .rs_addr(rsAddr), .rt_addr(rtAddr),
    .use_rs(useRs), .use_rt(useRt), .hz(hz_idex)
  );

  hz_cmp u_cmp_exmem (
    .reg_write(RegWrite_EXMEM), .wr_addr(WrR_EXMEM), .rs_addr(rsAddr), .rt_addr(rtAddr),
    .use_rs(useRs), .use_rt(useRt), .hz(hz_exmem)
  );

  hz_cmp u_cmp_memwb (
    .reg_write(RegWrite_MEMWB), .wr_addr(WrR_MEMWB), .rs_addr(rsAddr), .rt_addr(rtAddr),
    .use_rs(useRs), .use_rt(useRt), .hz(hz_memwb)
  );

`ifdef HAZARD_FORWARD_EN
  logic unused_late_hz;
  assign unused_late_hz = hz_exmem | hz_memwb;
  assign raw = hz_idex & MemRead_IDEX;
`else
  // No write-through bypass in the register file, so any in-flight writer must drain first.
  logic unused_mem_read;
  assign unused_mem_read = MemRead_IDEX;
  assign raw = hz_idex | hz_exmem | hz_memwb;
`endif

  always_comb begin
    state_d   = state_q;
    pcEn      = 1'b1;
    ifidEn    = 1'b1;
    freeze    = 1'b1;
    stallCtrl = 1'b0;
    flush     = 1'b0;
    if (rst) begin
      state_d = RUN;
    end else if (memBusy) begin
      pcEn   = 1'b0;
      ifidEn = 1'b0;
      freeze = 1'b0;
    end else begin
      case (state_q)
        RUN: begin
          if (takeBranch_EXMEM) begin
            flush   = 1'b1;
            state_d = FLUSH;
          end else if (halt_MEMWB) begin
            pcEn    = 1'b0;
            ifidEn  = 1'b0;
            freeze  = 1'b0;
            state_d = HALTED;
          end else if (raw) begin
            pcEn      = 1'b0;
            ifidEn    = 1'b0;
            stallCtrl = 1'b1;
          end
        end
        FLUSH: begin
          flush   = 1'b1;
          state_d = takeBranch_EXMEM ? FLUSH : RUN;
        end
        HALTED: begin
          pcEn   = 1'b0;
          ifidEn = 1'b0;
          freeze = 1'b0;
        end
        default: state_d = RUN;
      endcase
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (stallCtrl && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign stallCnt = cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - scoreboard bench for hazard_ctrl with directed and random stimulus
module tb_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  rsAddr, rtAddr, WrR_IDEX, WrR_EXMEM, WrR_MEMWB;
  logic        useRs, useRt;
  logic        RegWrite_IDEX, RegWrite_EXMEM, RegWrite_MEMWB, MemRead_IDEX;
  logic        takeBranch_EXMEM, halt_MEMWB, memBusy;
  logic        pcEn, ifidEn, freeze, stallCtrl, flush;
  logic [15:0] stallCnt;

  always #5 clk = ~clk;

  hazard_ctrl dut (
    .clk(clk), .rst(rst),
    .rsAddr(rsAddr), .rtAddr(rtAddr), .useRs(useRs), .useRt(useRt),
    .WrR_IDEX(WrR_IDEX), .WrR_EXMEM(WrR_EXMEM), .WrR_MEMWB(WrR_MEMWB),
    .RegWrite_IDEX(RegWrite_IDEX), .RegWrite_EXMEM(RegWrite_EXMEM),
    .RegWrite_MEMWB(RegWrite_MEMWB), .MemRead_IDEX(MemRead_IDEX),
    .takeBranch_EXMEM(takeBranch_EXMEM), .halt_MEMWB(halt_MEMWB), .memBusy(memBusy),
    .pcEn(pcEn), .ifidEn(ifidEn), .freeze(freeze), .stallCtrl(stallCtrl),
    .flush(flush), .stallCnt(stallCnt)
  );

  typedef struct packed {
    logic        pc_en;
    logic        ifid_en;
    logic        frz;
    logic        stl;
    logic        fl;
    logic [15:0] cnt;
  } resp_t;

  resp_t exp_q[$];
  int    n_checks = 0;
  int    n_fail   = 0;

  bit    m_halted   = 1'b0;
  bit    m_flushing = 1'b0;
  int    m_cnt      = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit uses(input bit we, input logic [2:0] w);
    return we && ((useRs && (w == rsAddr)) || (useRt && (w == rtAddr)));
  endfunction

  function automatic bit raw_ref();
`ifdef HAZARD_FORWARD_EN
    return uses(RegWrite_IDEX, WrR_IDEX) && MemRead_IDEX;
`else
    return uses(RegWrite_IDEX, WrR_IDEX) || uses(RegWrite_EXMEM, WrR_EXMEM) ||
           uses(RegWrite_MEMWB, WrR_MEMWB);
`endif
  endfunction

  // Predict this cycle's outputs from the current inputs, then advance the model across the edge.
  task automatic cycle();
    resp_t e;
    e = {1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'(m_cnt)};
    if (rst) begin
      m_halted = 0; m_flushing = 0; m_cnt = 0;
    end else if (memBusy) begin
      e.pc_en = 0; e.ifid_en = 0; e.frz = 0;
    end else if (m_halted) begin
      e.pc_en = 0; e.ifid_en = 0; e.frz = 0;
    end else if (m_flushing) begin
      e.fl = 1;
      m_flushing = takeBranch_EXMEM;
    end else if (takeBranch_EXMEM) begin
      e.fl = 1;
      m_flushing = 1;
    end else if (halt_MEMWB) begin
      e.pc_en = 0; e.ifid_en = 0; e.frz = 0;
      m_halted = 1;
    end else if (raw_ref()) begin
      e.pc_en = 0; e.ifid_en = 0; e.stl = 1;
      if (m_cnt < 65535) m_cnt++;
    end
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    rsAddr = 0; rtAddr = 0; useRs = 0; useRt = 0;
    WrR_IDEX = 0; WrR_EXMEM = 0; WrR_MEMWB = 0;
    RegWrite_IDEX = 0; RegWrite_EXMEM = 0; RegWrite_MEMWB = 0; MemRead_IDEX = 0;
    takeBranch_EXMEM = 0; halt_MEMWB = 0; memBusy = 0;
  endtask

  task automatic load_use();
    idle_inputs();
    rsAddr = 3; useRs = 1; WrR_IDEX = 3; RegWrite_IDEX = 1; MemRead_IDEX = 1;
  endtask

  resp_t mon_exp, mon_act;
  initial begin
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        mon_exp = exp_q.pop_front();
        mon_act = {pcEn, ifidEn, freeze, stallCtrl, flush, stallCnt};
        chk("sb_outputs", 32'(mon_act), 32'(mon_exp));
      end
    end
  end

  int cnt_before;
  initial begin
    idle_inputs();
    rst = 1;
    @(posedge clk); #1;
    cycle();
    rst = 0;
    #1;
    chk("rst_pcEn", 32'(pcEn), 1);
    chk("rst_freeze", 32'(freeze), 1);
    chk("rst_stallCtrl", 32'(stallCtrl), 0);
    chk("rst_stallCnt", 32'(stallCnt), 0);
    cycle();

    load_use(); #1;
    chk("lu_stallCtrl", 32'(stallCtrl), 1);
    chk("lu_pcEn", 32'(pcEn), 0);
    cycle();
    idle_inputs(); #1;
    chk("lu_stallCnt", 32'(stallCnt), 1);
    chk("lu_release_pcEn", 32'(pcEn), 1);
    cycle();

    load_use();
    MemRead_IDEX = 0; WrR_EXMEM = 5; rtAddr = 5; useRt = 1; RegWrite_EXMEM = 1; #1;
`ifdef HAZARD_FORWARD_EN
    chk("fwd_stallCtrl", 32'(stallCtrl), 0);
`else
    chk("fwd_stallCtrl", 32'(stallCtrl), 1);
`endif
    cycle();
    idle_inputs(); cycle();

    load_use(); takeBranch_EXMEM = 1; #1;
    chk("br0_flush", 32'(flush), 1);
    chk("br0_stallCtrl", 32'(stallCtrl), 0);
    cycle();
    takeBranch_EXMEM = 0; #1;
    chk("br1_flush", 32'(flush), 1);
    chk("br1_stallCtrl", 32'(stallCtrl), 0);
    cycle();
    chk("br2_flush", 32'(flush), 0);
    chk("br2_stallCtrl", 32'(stallCtrl), 1);
    cycle();
    idle_inputs(); cycle();

    halt_MEMWB = 1; #1;
    chk("halt_pcEn", 32'(pcEn), 0);
    cycle();
    halt_MEMWB = 0;
    for (int i = 0; i < 12; i++) begin
      if (i % 3 == 0) load_use(); else idle_inputs();
      takeBranch_EXMEM = i[0];
      cycle();
    end
    idle_inputs(); #1;
    chk("halted_pcEn", 32'(pcEn), 0);
    rst = 1; cycle(); rst = 0; #1;
    chk("unhalt_pcEn", 32'(pcEn), 1);
    cycle();

    load_use(); cycle();
    cnt_before = m_cnt;
    memBusy = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("busy_freeze", 32'(freeze), 0);
      cycle();
    end
    memBusy = 0;
    chk("busy_stallCnt", 32'(stallCnt), 32'(cnt_before));
    idle_inputs(); cycle();

    for (int i = 0; i < 3000; i++) begin
      rst              = ($urandom_range(99) < 2);
      memBusy          = ($urandom_range(99) < 10);
      takeBranch_EXMEM = ($urandom_range(99) < 10);
      halt_MEMWB       = ($urandom_range(99) < 3);
      rsAddr = 3'($urandom_range(3)); rtAddr = 3'($urandom_range(3));
      useRs  = 1'($urandom); useRt = 1'($urandom);
      WrR_IDEX  = 3'($urandom_range(3));
      WrR_EXMEM = 3'($urandom_range(3));
      WrR_MEMWB = 3'($urandom_range(3));
      RegWrite_IDEX  = 1'($urandom); RegWrite_EXMEM = 1'($urandom);
      RegWrite_MEMWB = 1'($urandom); MemRead_IDEX   = 1'($urandom);
      cycle();
    end

    rst = 1; idle_inputs(); cycle(); rst = 0;
    load_use();
    for (int i = 0; i < 65540; i++) cycle();
    chk("sat_stallCnt", 32'(stallCnt), 32'hFFFF);
    for (int i = 0; i < 3; i++) cycle();
    chk("sat_hold_stallCnt", 32'(stallCnt), 32'hFFFF);
    idle_inputs();

    for (int i = 0; i < 4; i++) begin
      if (exp_q.size() == 0) break;
      @(negedge clk); #1;
    end
    chk("sb_drain", 32'(exp_q.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
